// File: rtl/bsg_chip_pkg.sv
// Shared chip-level definitions for the bsg_tag configuration path.
// Holds the tag network sizing constants and the packed tag packet
// layout that the transmitter accepts, fields listed MSB to LSB.
package bsg_chip_pkg;

    localparam int tag_els_gp         = 1024;
    localparam int tag_lg_width_gp    = 4;
    localparam int tag_lg_els_gp      = $clog2(tag_els_gp);
    localparam int tag_max_payload_gp = (1 << tag_lg_width_gp) - 1;

    typedef struct packed {
        logic [tag_max_payload_gp-1:0] payload;
        logic [tag_lg_els_gp-1:0]      nodeID;
        logic                          data_not_reset;
        logic [tag_lg_width_gp-1:0]    len;
    } bsg_chip_tag_pkt_s;

endpackage

// File: rtl/bsg_counter_set_down.sv
// Loadable down-counter that saturates at zero.
// Ports:
//   clk_i, reset_i - clock and synchronous active-high reset
//   set_i, val_i   - load val_i this cycle (takes priority over down_i)
//   down_i         - decrement when nonzero
//   count_r_o      - current count
module bsg_counter_set_down #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               set_i,
    input  logic [width_p-1:0] val_i,
    input  logic               down_i,
    output logic [width_p-1:0] count_r_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r_o <= '0;
        end else if (set_i) begin
            count_r_o <= val_i;
        end else if (down_i && (count_r_o != '0)) begin
            count_r_o <= count_r_o - width_p'(1);
        end
    end

endmodule

// File: rtl/bsg_chip_tag_tx.sv
// Serializing bsg_tag transmitter. Sends one tag packet per valid/ready
// handshake as start bit, len, data_not_reset, nodeID, payload (each
// LSB-first), or a run of ones for a master reset. A one-cycle zero
// gap always follows, so the receiver never sees a false start bit.
// Ports:
//   clk_i, reset_i - tag clock and synchronous active-high reset
//   v_i, pkt_i     - packet valid / packet, taken when v_i & ready_and_o
//   ready_and_o    - idle and no master reset pending
//   mreset_v_i     - master reset request (wins over a packet)
//   mreset_yumi_o  - master reset request consumed this cycle
//   tag_data_o     - registered serial data
//   tag_en_o       - registered, high while bits are on the wire
//   busy_o         - transmitter not idle
module bsg_chip_tag_tx
    import bsg_chip_pkg::*;
#(
    parameter int els_p          = tag_els_gp,
    parameter int lg_width_p     = tag_lg_width_gp,
    parameter int reset_cycles_p = 2 ** (lg_width_p + 1)
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               v_i,
    input  logic [$bits(bsg_chip_tag_pkt_s)-1:0] pkt_i,
    output logic                               ready_and_o,
    input  logic                               mreset_v_i,
    output logic                               mreset_yumi_o,
    output logic                               tag_data_o,
    output logic                               tag_en_o,
    output logic                               busy_o
);

    localparam int lg_els_lp      = $clog2(els_p);
    localparam int max_payload_lp = (1 << lg_width_p) - 1;
    localparam int hdr_bits_lp    = 2 + lg_width_p + lg_els_lp;
    localparam int shift_width_lp = hdr_bits_lp + max_payload_lp;
    localparam int max_count_lp   = (shift_width_lp > reset_cycles_p) ? shift_width_lp : reset_cycles_p;
    localparam int ctr_width_lp   = $clog2(max_count_lp + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        MRESET,
        GAP
    } state_e;

    state_e                      state_r;
    bsg_chip_tag_pkt_s           pkt;
    logic [max_payload_lp-1:0]   payload_mask;
    logic [shift_width_lp-1:0]   load_bits;
    logic [shift_width_lp-1:0]   shift_r;
    logic [ctr_width_lp-1:0]     load_count;
    logic [ctr_width_lp-1:0]     count_r;
    logic                        pkt_accept;
    logic                        mreset_accept;

    assign pkt = bsg_chip_tag_pkt_s'(pkt_i);

    assign ready_and_o   = (state_r == IDLE) & ~mreset_v_i;
    assign mreset_yumi_o = (state_r == IDLE) & mreset_v_i;
    assign busy_o        = (state_r != IDLE);
    assign pkt_accept    = v_i & ready_and_o;
    assign mreset_accept = mreset_yumi_o;

    // Payload bits above len are cleared so stale high bits never
    // sit in the shift register, even though the counter stops first.
    always_comb begin
        payload_mask = '0;
        for (int unsigned i = 0; i < max_payload_lp; i++) begin
            payload_mask[i] = (i < int'(pkt.len));
        end
        load_bits  = {pkt.payload & payload_mask, pkt.nodeID, pkt.data_not_reset, pkt.len, 1'b1};
        load_count = ctr_width_lp'(hdr_bits_lp - 1) + ctr_width_lp'(pkt.len);
    end

    bsg_counter_set_down #(
        .width_p (ctr_width_lp)
    ) bit_counter (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .set_i     (pkt_accept | mreset_accept),
        .val_i     (mreset_accept ? ctr_width_lp'(reset_cycles_p - 1) : load_count),
        .down_i    ((state_r == SEND) | (state_r == MRESET)),
        .count_r_o (count_r)
    );

    // The start bit goes straight to tag_data_o at the handshake edge,
    // so the shift register holds the remainder already shifted by one.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= IDLE;
            tag_data_o <= 1'b0;
            tag_en_o   <= 1'b0;
            shift_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mreset_accept) begin
                        state_r    <= MRESET;
                        tag_data_o <= 1'b1;
                        tag_en_o   <= 1'b1;
                    end else if (pkt_accept) begin
                        state_r    <= SEND;
                        tag_data_o <= load_bits[0];
                        tag_en_o   <= 1'b1;
                        shift_r    <= load_bits >> 1;
                    end
                end
                SEND: begin
                    if (count_r == '0) begin
                        state_r    <= GAP;
                        tag_data_o <= 1'b0;
                        tag_en_o   <= 1'b0;
                    end else begin
                        tag_data_o <= shift_r[0];
                        shift_r    <= shift_r >> 1;
                    end
                end
                MRESET: begin
                    if (count_r == '0) begin
                        state_r    <= GAP;
                        tag_data_o <= 1'b0;
                        tag_en_o   <= 1'b0;
                    end else begin
                        tag_data_o <= 1'b1;
                    end
                end
                GAP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_chip_tag_tx.sv
// Directed bench for bsg_chip_tag_tx with a behavioural bsg_tag receiver
// for the random-packet pass. Outputs are sampled at the falling edge.
module tb_bsg_chip_tag_tx;
    import bsg_chip_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_i;
    logic              v_i;
    bsg_chip_tag_pkt_s pkt_s;
    logic              ready_and_o;
    logic              mreset_v_i;
    logic              mreset_yumi_o;
    logic              tag_data_o;
    logic              tag_en_o;
    logic              busy_o;

    bsg_chip_tag_tx #(
        .els_p          (1024),
        .lg_width_p     (4),
        .reset_cycles_p (32)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .v_i           (v_i),
        .pkt_i         (pkt_s),
        .ready_and_o   (ready_and_o),
        .mreset_v_i    (mreset_v_i),
        .mreset_yumi_o (mreset_yumi_o),
        .tag_data_o    (tag_data_o),
        .tag_en_o      (tag_en_o),
        .busy_o        (busy_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bsg_chip_tag_pkt_s make_pkt(input int len, input int dnr, input int id, input int payload);
        bsg_chip_tag_pkt_s p;
        p.len            = 4'(len);
        p.data_not_reset = 1'(dnr);
        p.nodeID         = 10'(id);
        p.payload        = 15'(payload);
        return p;
    endfunction

    // Independent wire-order model: start, len, dnr, nodeID, len payload bits.
    task automatic build_stream(input bsg_chip_tag_pkt_s p, output logic [63:0] bits, output int n);
        bits = '0;
        n = 0;
        bits[n] = 1'b1; n++;
        for (int i = 0; i < 4; i++) begin bits[n] = p.len[i]; n++; end
        bits[n] = p.data_not_reset; n++;
        for (int i = 0; i < 10; i++) begin bits[n] = p.nodeID[i]; n++; end
        for (int i = 0; i < int'(p.len); i++) begin bits[n] = p.payload[i]; n++; end
    endtask

    // Wire-order string, first character is bit 0.
    task automatic str_to_bits(input string s, output logic [63:0] bits, output int n);
        bits = '0;
        n = s.len();
        for (int i = 0; i < n; i++) bits[i] = (s[i] == "1");
    endtask

    task automatic send_and_check(input string tag, input bsg_chip_tag_pkt_s p, input logic [63:0] bits, input int n);
        @(negedge clk);
        v_i = 1'b1;
        pkt_s = p;
        #1;
        check({tag, "_ready"}, 32'(ready_and_o), 32'd1);
        @(negedge clk);
        v_i = 1'b0;
        pkt_s = make_pkt($urandom, $urandom, $urandom, $urandom);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_en%0d", tag, k), 32'(tag_en_o), 32'd1);
            check($sformatf("%s_bit%0d", tag, k), 32'(tag_data_o), 32'(bits[k]));
            @(negedge clk);
        end
        check({tag, "_gap_en"}, 32'(tag_en_o), 32'd0);
        check({tag, "_gap_data"}, 32'(tag_data_o), 32'd0);
        check({tag, "_gap_ready"}, 32'(ready_and_o), 32'd0);
        check({tag, "_gap_busy"}, 32'(busy_o), 32'd1);
        @(negedge clk);
        check({tag, "_ready_back"}, 32'(ready_and_o), 32'd1);
        check({tag, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    // Behavioural receiver state
    int rx_st, rx_cnt, rx_len;
    logic [14:0] rx_hdr;
    logic [14:0] rx_pay;
    bsg_chip_tag_pkt_s sent_q[$];
    bsg_chip_tag_pkt_s recv_q[$];

    task automatic push_rx(input logic [14:0] hdr, input logic [14:0] pay);
        bsg_chip_tag_pkt_s p;
        p.len            = hdr[3:0];
        p.data_not_reset = hdr[4];
        p.nodeID         = hdr[14:5];
        p.payload        = pay;
        recv_q.push_back(p);
    endtask

    task automatic decode_step(input logic d);
        case (rx_st)
            0: if (d) begin rx_st = 1; rx_cnt = 0; rx_hdr = '0; end
            1: begin
                rx_hdr[rx_cnt] = d;
                rx_cnt++;
                if (rx_cnt == 15) begin
                    rx_len = int'(rx_hdr[3:0]);
                    rx_pay = '0;
                    rx_cnt = 0;
                    if (rx_len == 0) begin push_rx(rx_hdr, rx_pay); rx_st = 0; end
                    else rx_st = 2;
                end
            end
            default: begin
                rx_pay[rx_cnt] = d;
                rx_cnt++;
                if (rx_cnt == rx_len) begin push_rx(rx_hdr, rx_pay); rx_st = 0; end
            end
        endcase
    endtask

    logic [63:0] bits;
    int n;
    bsg_chip_tag_pkt_s p1, p2, p3;
    logic dat_log[0:89];
    logic en_log[0:89];

    initial begin
        int hs_count, h0, h1, waited;
        bit drop;

        reset_i = 1'b1;
        v_i = 1'b0;
        mreset_v_i = 1'b0;
        pkt_s = '0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        #1;
        check("rst_data", 32'(tag_data_o), 32'd0);
        check("rst_en", 32'(tag_en_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ready", 32'(ready_and_o), 32'd1);
        check("rst_yumi", 32'(mreset_yumi_o), 32'd0);

        // 1: basic packet, hand-derived wire pattern
        p1 = make_pkt(3, 1, 5, 15'b101);
        str_to_bits("1110011010000000101", bits, n);
        check("s1_len", 32'(n), 32'd19);
        send_and_check("s1", p1, bits, n);

        // 2: zero-length payload, max node id
        p2 = make_pkt(0, 0, 1023, 15'h7FFF);
        str_to_bits("1000001111111111", bits, n);
        send_and_check("s2", p2, bits, n);

        // 3: full payload, two packets back to back with v_i held high
        p3 = make_pkt(15, 1, 10'h2A5, 15'h7FFF);
        build_stream(p3, bits, n);
        check("s3_len", 32'(n), 32'd31);
        @(negedge clk);
        v_i = 1'b1;
        pkt_s = p3;
        hs_count = 0; h0 = 0; h1 = 0; drop = 1'b0;
        for (int c = 0; c < 90; c++) begin
            if (c != 0) @(negedge clk);
            if (drop) begin v_i = 1'b0; drop = 1'b0; end
            #1;
            dat_log[c] = tag_data_o;
            en_log[c] = tag_en_o;
            if (v_i && ready_and_o) begin
                if (hs_count == 0) h0 = c; else h1 = c;
                hs_count++;
                if (hs_count == 2) drop = 1'b1;
            end
        end
        check("s3_handshakes", 32'(hs_count), 32'd2);
        if (hs_count == 2 && h1 + 1 < 90) begin
            check("s3_throughput", 32'(h1 - h0), 32'd33);
            for (int k = 0; k < 31; k++) begin
                check($sformatf("s3_bit%0d", k), 32'(dat_log[h0 + 1 + k]), 32'(bits[k]));
                check($sformatf("s3_en%0d", k), 32'(en_log[h0 + 1 + k]), 32'd1);
            end
            check("s3_gap_data", 32'(dat_log[h0 + 32]), 32'd0);
            check("s3_gap_en", 32'(en_log[h0 + 32]), 32'd0);
            check("s3_second_start", 32'(dat_log[h1 + 1]), 32'd1);
        end
        waited = 0;
        while (busy_o && waited < 64) begin @(negedge clk); waited++; end
        check("s3_drain", 32'(busy_o), 32'd0);

        // 4: master reset wins over simultaneous packet
        @(negedge clk);
        mreset_v_i = 1'b1;
        v_i = 1'b1;
        pkt_s = p1;
        #1;
        check("s4_yumi", 32'(mreset_yumi_o), 32'd1);
        check("s4_ready", 32'(ready_and_o), 32'd0);
        @(negedge clk);
        mreset_v_i = 1'b0;
        for (int k = 0; k < 32; k++) begin
            check($sformatf("s4_one%0d", k), 32'(tag_data_o), 32'd1);
            check($sformatf("s4_en%0d", k), 32'(tag_en_o), 32'd1);
            check($sformatf("s4_nrdy%0d", k), 32'(ready_and_o), 32'd0);
            @(negedge clk);
        end
        check("s4_gap_data", 32'(tag_data_o), 32'd0);
        check("s4_gap_en", 32'(tag_en_o), 32'd0);
        check("s4_gap_ready", 32'(ready_and_o), 32'd0);
        @(negedge clk);
        #1;
        check("s4_pkt_ready", 32'(ready_and_o), 32'd1);
        @(negedge clk);
        v_i = 1'b0;
        check("s4_pkt_start", 32'(tag_data_o), 32'd1);
        check("s4_pkt_en", 32'(tag_en_o), 32'd1);
        waited = 0;
        while (busy_o && waited < 64) begin @(negedge clk); waited++; end
        check("s4_drain", 32'(busy_o), 32'd0);

        // 5: reset while bit 7 of the basic packet is on the wire
        str_to_bits("1110011010000000101", bits, n);
        @(negedge clk);
        v_i = 1'b1;
        pkt_s = p1;
        #1;
        check("s5_ready", 32'(ready_and_o), 32'd1);
        @(negedge clk);
        v_i = 1'b0;
        for (int k = 0; k < 7; k++) begin
            check($sformatf("s5_bit%0d", k), 32'(tag_data_o), 32'(bits[k]));
            @(negedge clk);
        end
        check("s5_bit7", 32'(tag_data_o), 32'(bits[7]));
        reset_i = 1'b1;
        @(negedge clk);
        check("s5_data", 32'(tag_data_o), 32'd0);
        check("s5_en", 32'(tag_en_o), 32'd0);
        check("s5_busy", 32'(busy_o), 32'd0);
        reset_i = 1'b0;
        #1;
        check("s5_ready_after", 32'(ready_and_o), 32'd1);

        // 6: random traffic against the receiver model
        rx_st = 0; rx_cnt = 0; rx_len = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            decode_step(tag_data_o);
            v_i = 1'($urandom_range(0, 1));
            pkt_s = make_pkt($urandom, $urandom, $urandom, $urandom);
            #1;
            if (v_i && ready_and_o) sent_q.push_back(pkt_s);
        end
        v_i = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            decode_step(tag_data_o);
        end
        check("s6_idle", 32'(busy_o), 32'd0);
        check("s6_rx_idle", 32'(rx_st), 32'd0);
        check("s6_count", 32'(recv_q.size()), 32'(sent_q.size()));
        for (int i = 0; i < sent_q.size() && i < recv_q.size(); i++) begin
            logic [14:0] mask;
            mask = '0;
            for (int b = 0; b < 15; b++) mask[b] = (b < int'(sent_q[i].len));
            check($sformatf("s6_len%0d", i), 32'(recv_q[i].len), 32'(sent_q[i].len));
            check($sformatf("s6_dnr%0d", i), 32'(recv_q[i].data_not_reset), 32'(sent_q[i].data_not_reset));
            check($sformatf("s6_id%0d", i), 32'(recv_q[i].nodeID), 32'(sent_q[i].nodeID));
            check($sformatf("s6_pay%0d", i), 32'(recv_q[i].payload), 32'(sent_q[i].payload & mask));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
